audio_i2s_tx: RTL and testbench

Serial transmitter for the core's 16-bit stereo PCM output. It is the outbound end of the audio path: it accepts left/right sample pairs from the sound engine through a valid/ready handshake and buffers one pair. It then shifts the samples out as standard Philips I2S (BCLK, LRCK, SDATA) to the board codec/DAC. Everything runs in the 50 MHz domain. BCLK is derived by an internal divider, so no second clock is needed.

---
 rtl/audio_i2s_tx.sv | 177 +++++++++++++++++
 tb/tb_audio_i2s_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// audio_i2s_tx
// Philips I2S transmitter for 16-bit stereo PCM, single 50 MHz clock domain.
// Accepts L/R pairs through a valid/ready handshake into a one-pair holding
// buffer. It moves the pair into the active shifter registers at each frame
// boundary and serialises them with BCLK generated by an internal divider.
// A frame is 64 BCLKs, with one 32-bit slot per channel. Each 16-bit sample
// is sent MSB first, starting one BCLK after the LRCK transition.
//
// Ports
//   CLK_50M       system clock (only clock)
//   RESET         synchronous, active-high reset
//   sample_l/r    16-bit PCM samples, left/right
//   is_signed     1 = two's complement, 0 = offset binary (sampled with data)
//   sample_valid  producer holds a pair
//   sample_ready  holding buffer empty; transfer on valid && ready
//   underrun_clr  clears the sticky underrun flag
//   i2s_bclk      bit clock, period 2*CLK_DIV system clocks
//   i2s_lrck      word select, 0 = left, 1 = right
//   i2s_data      serial data, updated on BCLK falling edges
//   frame_strobe  1-cycle pulse when a new frame starts in the shifter
//   underrun      sticky flag: a frame started with no new pair available
// -----------------------------------------------------------------------------
module audio_i2s_tx #(
  parameter int CLK_DIV          = 8,
  parameter bit MUTE_ON_UNDERRUN = 1'b0
) (
  input  logic        CLK_50M,
  input  logic        RESET,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        is_signed,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        underrun_clr,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_data,
  output logic        frame_strobe,
  output logic        underrun
);

  localparam int DATA_W = 16;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Offset-binary input becomes two's complement by flipping the MSB.
  function automatic logic signed [DATA_W-1:0] to_twos(
    input logic [DATA_W-1:0] s,
    input logic              sg
  );
    to_twos = sg ? signed'(s) : signed'({~s[DATA_W-1], s[DATA_W-2:0]});
  endfunction

  // Serial bit for frame position b: slot bits 1..16 carry the sample
  // MSB first, and every other position in the 32-bit slot is zero.
  function automatic logic slot_bit(
    input logic [5:0]               b,
    input logic signed [DATA_W-1:0] l,
    input logic signed [DATA_W-1:0] r
  );
    logic [4:0]        p;
    logic [4:0]        rem;
    logic [DATA_W-1:0] ch;
    p        = b[4:0];
    ch       = b[5] ? r : l;
    rem      = 5'(DATA_W) - p;
    slot_bit = 1'b0;
    if (p >= 5'd1 && p <= 5'(DATA_W))
      slot_bit = ch[rem[3:0]];
  endfunction

  logic [DIV_W-1:0]         div_cnt;
  logic                     bclk_q;
  logic                     lrck_q;
  logic                     data_q;
  logic                     strobe_q;
  logic                     underrun_q;
  logic [5:0]               bit_cnt;
  logic                     primed;
  logic                     vld_p0;
  logic signed [DATA_W-1:0] hold_l_p0;
  logic signed [DATA_W-1:0] hold_r_p0;
  logic signed [DATA_W-1:0] act_l_p1;
  logic signed [DATA_W-1:0] act_r_p1;

  logic       div_wrap;
  logic       fall_evt;
  logic [5:0] bit_nxt;
  logic       frame_load;
  logic       xfer;
  logic       bypass;
  logic       underrun_set;

  assign sample_ready = !vld_p0 && !RESET;
  assign xfer         = sample_valid && sample_ready;

  assign div_wrap     = (div_cnt == DIV_LAST);
  assign fall_evt     = div_wrap && bclk_q;
  assign bit_nxt      = bit_cnt + 6'd1;
  assign frame_load   = fall_evt && (bit_cnt == 6'd63);
  // A pair offered in the load cycle with an empty buffer goes straight to
  // the shifter so it is not delayed by a whole frame.
  assign bypass       = frame_load && !vld_p0 && xfer;
  assign underrun_set = frame_load && !vld_p0 && !xfer && primed;

  // Stage p0: holding buffer (data registers need no reset; vld_p0 gates them)
  always_ff @(posedge CLK_50M) begin
    if (xfer && !bypass) begin
      hold_l_p0 <= to_twos(sample_l, is_signed);
      hold_r_p0 <= to_twos(sample_r, is_signed);
    end
  end

  // Stage p1: active shifter registers, divider, frame counter, serial outputs
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      div_cnt    <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      data_q     <= 1'b0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      bit_cnt    <= 6'd63;
      primed     <= 1'b0;
      vld_p0     <= 1'b0;
      act_l_p1   <= '0;
      act_r_p1   <= '0;
    end else begin
      div_cnt  <= div_wrap ? '0 : div_cnt + 1'b1;
      strobe_q <= frame_load;

      if (div_wrap)
        bclk_q <= ~bclk_q;

      // lrck/data change on the BCLK fall so they are stable at the rise.
      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        lrck_q  <= bit_nxt[5];
        data_q  <= slot_bit(bit_nxt, act_l_p1, act_r_p1);
      end

      if (frame_load) begin
        if (vld_p0) begin
          act_l_p1 <= hold_l_p0;
          act_r_p1 <= hold_r_p0;
          vld_p0   <= 1'b0;
        end else if (xfer) begin
          act_l_p1 <= to_twos(sample_l, is_signed);
          act_r_p1 <= to_twos(sample_r, is_signed);
        end else if (primed && MUTE_ON_UNDERRUN) begin
          act_l_p1 <= '0;
          act_r_p1 <= '0;
        end
      end

      if (xfer) begin
        primed <= 1'b1;
        if (!bypass)
          vld_p0 <= 1'b1;
      end

      // Set has priority over a simultaneous clear.
      if (underrun_set)
        underrun_q <= 1'b1;
      else if (underrun_clr)
        underrun_q <= 1'b0;
    end
  end

  assign i2s_bclk     = bclk_q;
  assign i2s_lrck     = lrck_q;
  assign i2s_data     = data_q;
  assign frame_strobe = strobe_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_audio_i2s_tx
// Directed bench for audio_i2s_tx with default parameters (CLK_DIV=8, repeat
// last pair on underrun). A background monitor acts as the codec. It samples
// i2s_data/i2s_lrck on every BCLK rise after a frame_strobe and packs the 64
// bits of each frame into a word, first bit in the MSB.
// -----------------------------------------------------------------------------
module tb_audio_i2s_tx;

  logic        CLK_50M = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        is_signed = 1'b1;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        underrun_clr = 1'b0;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_data;
  logic        frame_strobe;
  logic        underrun;

  audio_i2s_tx dut (
    .CLK_50M      (CLK_50M),
    .RESET        (RESET),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .is_signed    (is_signed),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .underrun_clr (underrun_clr),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_data     (i2s_data),
    .frame_strobe (frame_strobe),
    .underrun     (underrun)
  );

  always #10 CLK_50M = ~CLK_50M;

  int cyc = 0;
  always @(posedge CLK_50M) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] d;
    logic [63:0] lr;
    int          period;
  } frame_t;

  frame_t fq[$];

  localparam logic [63:0] LR_EXP = 64'h00000000_FFFFFFFF;

  // Codec model
  logic        mon_on = 1'b0;
  logic        mon_prev = 1'b0;
  int          mon_n = 0;
  int          mon_last = 0;
  int          mon_period = 0;
  logic [63:0] mon_d = '0;
  logic [63:0] mon_lr = '0;

  always @(negedge CLK_50M) begin
    if (RESET) begin
      mon_on   = 1'b0;
      mon_prev = 1'b0;
    end else begin
      if (frame_strobe) begin
        mon_on     = 1'b1;
        mon_n      = 0;
        mon_d      = '0;
        mon_lr     = '0;
        mon_period = cyc - mon_last;
        mon_last   = cyc;
      end
      if (mon_on && i2s_bclk && !mon_prev) begin
        mon_d  = {mon_d[62:0], i2s_data};
        mon_lr = {mon_lr[62:0], i2s_lrck};
        mon_n++;
        if (mon_n == 64) begin
          fq.push_back('{d: mon_d, lr: mon_lr, period: mon_period});
          mon_on = 1'b0;
        end
      end
      mon_prev = i2s_bclk;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input logic [15:0] l, input logic [15:0] r);
    exp_word = {1'b0, l, 15'h0000, 1'b0, r, 15'h0000};
  endfunction

  task automatic push(input logic [15:0] l, input logic [15:0] r, input logic sg);
    int t;
    sample_l     = l;
    sample_r     = r;
    is_signed    = sg;
    sample_valid = 1'b1;
    t = 0;
    while (!sample_ready && t < 3000) begin
      @(negedge CLK_50M);
      t++;
    end
    if (t >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: observed ready=%b after %0d cycles, expected ready=1", sample_ready, t);
    end
    @(negedge CLK_50M);
    sample_valid = 1'b0;
  endtask

  task automatic get_frame(input string tag, output frame_t f);
    int t;
    t = 0;
    while (fq.size() == 0 && t < 2500) begin
      @(negedge CLK_50M);
      t++;
    end
    if (fq.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: observed no frame in %0d cycles, expected one frame", tag, t);
      f = '{d: 'x, lr: 'x, period: -1};
    end else begin
      f = fq.pop_front();
    end
  endtask

  task automatic wait_strobe(input string tag);
    int t;
    t = 0;
    do begin
      @(negedge CLK_50M);
      t++;
    end while (!frame_strobe && t < 2500);
    if (!frame_strobe) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: observed no frame_strobe in %0d cycles, expected a pulse", tag, t);
    end
  endtask

  initial begin
    #(20 * 40000);
    $display("FAIL watchdog: observed simulation still running, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t f;
    int     s;

    // 1. Reset / idle
    repeat (5) @(negedge CLK_50M);
    chk_bit("rst_bclk",   i2s_bclk, 1'b0);
    chk_bit("rst_lrck",   i2s_lrck, 1'b0);
    chk_bit("rst_data",   i2s_data, 1'b0);
    chk_bit("rst_strobe", frame_strobe, 1'b0);
    chk_bit("rst_underrun", underrun, 1'b0);
    chk_bit("rst_ready",  sample_ready, 1'b0);
    RESET = 1'b0;
    #1;
    chk_bit("ready_after_release", sample_ready, 1'b1);
    repeat (7) @(negedge CLK_50M);
    chk_bit("bclk_low_c7", i2s_bclk, 1'b0);
    @(negedge CLK_50M);
    chk_bit("bclk_rise_c8", i2s_bclk, 1'b1);
    repeat (7) @(negedge CLK_50M);
    chk_bit("strobe_low_c15", frame_strobe, 1'b0);
    @(negedge CLK_50M);
    chk_bit("strobe_c16", frame_strobe, 1'b1);
    chk_bit("bclk_fall_c16", i2s_bclk, 1'b0);
    chk_bit("lrck_c16", i2s_lrck, 1'b0);
    chk_bit("no_underrun_unprimed", underrun, 1'b0);

    // 2. Serial format, signed input
    push(16'hA5C3, 16'h8001, 1'b1);
    chk_bit("strobe_one_cycle", frame_strobe, 1'b0);
    get_frame("f0", f);
    chk_word("f0_idle_zero", f.d, 64'h0);
    chk_word("f0_lrck", f.lr, LR_EXP);
    get_frame("f1", f);
    chk_word("f1_data_a5c3_8001", f.d, exp_word(16'hA5C3, 16'h8001));
    chk_word("f1_lrck", f.lr, LR_EXP);
    chk_word("f1_period", 64'(f.period), 64'd1024);
    chk_bit("f1_no_underrun", underrun, 1'b0);

    // 3. Offset binary input
    push(16'h0000, 16'hFFFF, 1'b0);
    get_frame("f2", f);
    chk_word("f2_offset_bin", f.d, exp_word(16'h8000, 16'h7FFF));
    chk_word("f2_period", 64'(f.period), 64'd1024);

    // 4. Backpressure: three pairs back to back
    push(16'h0F0F, 16'hF0F0, 1'b1);
    chk_bit("bp_ready_low_p1", sample_ready, 1'b0);
    push(16'h7FFF, 16'h8000, 1'b1);
    chk_bit("bp_ready_low_p2", sample_ready, 1'b0);
    push(16'h1234, 16'h5678, 1'b1);
    get_frame("f3", f);
    chk_word("f3_p1", f.d, exp_word(16'h0F0F, 16'hF0F0));
    chk_word("f3_period", 64'(f.period), 64'd1024);
    get_frame("f4", f);
    chk_word("f4_p2", f.d, exp_word(16'h7FFF, 16'h8000));
    chk_word("f4_period", 64'(f.period), 64'd1024);
    get_frame("f5", f);
    chk_word("f5_p3", f.d, exp_word(16'h1234, 16'h5678));
    chk_bit("f5_no_underrun", underrun, 1'b0);

    // 5. Underrun: last pair repeats, sticky flag, clear, set-beats-clear
    get_frame("f6", f);
    chk_word("f6_repeat", f.d, exp_word(16'h1234, 16'h5678));
    chk_word("f6_period", 64'(f.period), 64'd1024);
    chk_bit("underrun_set", underrun, 1'b1);
    underrun_clr = 1'b1;
    @(negedge CLK_50M);
    underrun_clr = 1'b0;
    chk_bit("underrun_cleared", underrun, 1'b0);
    underrun_clr = 1'b1;
    wait_strobe("tie");
    chk_bit("underrun_set_wins", underrun, 1'b1);
    underrun_clr = 1'b0;

    // 6. Mid-frame reset with a full holding buffer
    s = cyc;
    underrun_clr = 1'b1;
    @(negedge CLK_50M);
    underrun_clr = 1'b0;
    chk_bit("underrun_cleared2", underrun, 1'b0);
    push(16'hDEAD, 16'hBEEF, 1'b1);
    chk_bit("mid_hold_full", sample_ready, 1'b0);
    while (cyc < s + 328) @(negedge CLK_50M);
    chk_bit("mid_bclk_high", i2s_bclk, 1'b1);
    RESET = 1'b1;
    @(negedge CLK_50M);
    chk_bit("mid_rst_bclk",   i2s_bclk, 1'b0);
    chk_bit("mid_rst_lrck",   i2s_lrck, 1'b0);
    chk_bit("mid_rst_data",   i2s_data, 1'b0);
    chk_bit("mid_rst_strobe", frame_strobe, 1'b0);
    chk_bit("mid_rst_underrun", underrun, 1'b0);
    chk_bit("mid_rst_ready",  sample_ready, 1'b0);
    fq.delete();
    RESET = 1'b0;
    #1;
    chk_bit("mid_hold_emptied", sample_ready, 1'b1);
    get_frame("g0", f);
    chk_word("g0_zero", f.d, 64'h0);
    chk_word("g0_lrck", f.lr, LR_EXP);
    chk_bit("g0_no_underrun", underrun, 1'b0);
    get_frame("g1", f);
    chk_word("g1_zero", f.d, 64'h0);
    chk_word("g1_period", 64'(f.period), 64'd1024);
    chk_bit("g1_no_underrun", underrun, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
